// File: rtl/heap_pq_pkg.sv
// Shared types for the heap priority queue: FSM states, op codes and the
// ordering compare used by both heap directions.
package heap_pq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP_RD,
    S_UP_CMP,
    S_DN_LAST,
    S_DN_RDL,
    S_DN_RDR,
    S_DN_CMP,
    S_DN_END
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } op_e;

  // Keys are zero-extended to this width so one compare serves any W_D up to 64.
  localparam int KEY_MAX_W = 64;
  typedef logic [KEY_MAX_W-1:0] key_wide_t;

  function automatic logic better(input logic mode_min, input key_wide_t a, input key_wide_t b);
    return mode_min ? (a <= b) : (a >= b);
  endfunction

endpackage

// File: rtl/heap_pq_if.sv
// Producer/consumer bus of the heap priority queue; the heap is the slave,
// the producer/consumer side is the master.
interface heap_pq_if #(
  parameter int W_D = 32,
  parameter int W_A = 8
);
  logic           write_valid;
  logic [W_D-1:0] write_data;
  logic           write_ready;
  logic           read_request;
  logic           read_ready;
  logic [W_D-1:0] read_data;
  logic           read_valid;
  logic           read_empty;
  logic           full;
  logic [W_A-1:0] count;
  logic [W_A-1:0] max_count;

  modport master (
    output write_valid, write_data, read_request,
    input  write_ready, read_ready, read_data, read_valid, read_empty, full, count, max_count
  );

  modport slave (
    input  write_valid, write_data, read_request,
    output write_ready, read_ready, read_data, read_valid, read_empty, full, count, max_count
  );
endinterface

// File: rtl/heap_pq_ram.sv
// Simple dual-port heap storage: one write port, one read port whose address
// is registered, giving read data one cycle after the address is presented.
module heap_pq_ram #(
  parameter int W_D = 32,
  parameter int W_A = 8
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic [W_A-1:0] waddr_i,
  input  logic [W_D-1:0] wdata_i,
  input  logic [W_A-1:0] raddr_i,
  output logic [W_D-1:0] rdata_o
);

  logic [W_D-1:0] mem_q [2**W_A];
  logic [W_A-1:0] raddr_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    raddr_q <= raddr_i;
  end

  assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/heap_pq.sv
// Binary-heap priority queue in on-chip RAM with push, pop and replace.
// Define HEAP_PQ_STATS_EN to build the max_count high-water tracker.
module heap_pq
  import heap_pq_pkg::*;
#(
  parameter int W_D      = 32,
  parameter int W_A      = 8,
  parameter int MODE_MIN = 1
) (
  input logic       CLK,
  input logic       RST,
  heap_pq_if.slave  bus
);

  localparam logic [W_D-1:0] WORST   = {W_D{MODE_MIN != 0}};
  localparam logic [W_A:0]   IDX_ONE = (W_A+1)'(1);

  function automatic logic bt(input logic [W_D-1:0] a, input logic [W_D-1:0] b);
    return better(MODE_MIN != 0, key_wide_t'(a), key_wide_t'(b));
  endfunction

  state_e         state_q;
  logic [W_A-1:0] count_q, count_d;
  logic [W_D-1:0] root_q, rdata_q, new_q, left_q;
  logic           rvalid_q;
  logic [W_A:0]   idx_q;

  logic           full, rd_rdy, wr_rdy, rd_acc, wr_acc;
  op_e            op;
  logic [W_A:0]   cnt_ext, par_idx, left_idx, right_idx, child_idx;
  logic [W_D-1:0] parent_v, right_v, child_v;
  logic           par_better, take_left, new_better;

  logic           ram_we;
  logic [W_A-1:0] ram_waddr, ram_raddr;
  logic [W_D-1:0] ram_wdata, ram_rdata;

  assign full   = (count_q == {W_A{1'b1}});
  assign rd_rdy = (state_q == S_IDLE) && (count_q != '0);
  assign wr_rdy = (state_q == S_IDLE) && (!full || bus.read_request);
  assign rd_acc = bus.read_request && rd_rdy;
  assign wr_acc = bus.write_valid && wr_rdy;

  always_comb begin
    op = OP_NONE;
    if (rd_acc && wr_acc)  op = OP_REPLACE;
    else if (rd_acc)       op = OP_POP;
    else if (wr_acc)       op = OP_PUSH;
  end

  always_comb begin
    count_d = count_q;
    case (op)
      OP_PUSH: count_d = count_q + W_A'(1);
      OP_POP:  count_d = count_q - W_A'(1);
      default: ;
    endcase
  end

  // Index 1 lives only in root_q, so an upheap parent at the root is taken from there.
  assign cnt_ext    = {1'b0, count_q};
  assign par_idx    = idx_q >> 1;
  assign parent_v   = (par_idx == IDX_ONE) ? root_q : ram_rdata;
  assign par_better = bt(parent_v, new_q);
  assign left_idx   = {idx_q[W_A-1:0], 1'b0};
  assign right_idx  = {idx_q[W_A-1:0], 1'b1};
  assign right_v    = (right_idx > cnt_ext) ? WORST : ram_rdata;
  assign take_left  = bt(left_q, right_v);
  assign child_v    = take_left ? left_q : right_v;
  assign child_idx  = take_left ? left_idx : right_idx;
  assign new_better = bt(new_q, child_v);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = idx_q[W_A-1:0];
    ram_wdata = new_q;
    ram_raddr = '0;
    case (state_q)
      S_IDLE: begin
        if (op == OP_POP) ram_raddr = count_q;
        if (op == OP_PUSH && count_q == '0) begin
          ram_we    = 1'b1;
          ram_waddr = W_A'(1);
          ram_wdata = bus.write_data;
        end
      end
      S_UP_RD:  ram_raddr = par_idx[W_A-1:0];
      S_UP_CMP: begin
        ram_we = 1'b1;
        if (!par_better) ram_wdata = parent_v;
      end
      S_DN_RDL: ram_raddr = left_idx[W_A-1:0];
      S_DN_RDR: ram_raddr = right_idx[W_A-1:0];
      S_DN_CMP: begin
        if (!new_better) begin
          ram_we    = 1'b1;
          ram_wdata = child_v;
        end
      end
      S_DN_END: ram_we = 1'b1;
      default: ;
    endcase
  end

  heap_pq_ram #(.W_D(W_D), .W_A(W_A)) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

`ifdef HEAP_PQ_STATS_EN
  logic [W_A-1:0] maxc_q;

  always_ff @(posedge CLK) begin
    if (RST)                  maxc_q <= '0;
    else if (count_d > maxc_q) maxc_q <= count_d;
  end

  assign bus.max_count = maxc_q;
`else
  assign bus.max_count = '0;
`endif

  // Pop-type ops hand out the old root on the next cycle, independent of the traversal.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      root_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      idx_q    <= '0;
      new_q    <= '0;
      left_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      count_q  <= count_d;
      case (state_q)
        S_IDLE: begin
          case (op)
            OP_REPLACE: begin
              rdata_q  <= root_q;
              rvalid_q <= 1'b1;
              new_q    <= bus.write_data;
              idx_q    <= IDX_ONE;
              state_q  <= S_DN_RDL;
            end
            OP_POP: begin
              rdata_q  <= root_q;
              rvalid_q <= 1'b1;
              if (count_q != W_A'(1)) begin
                idx_q   <= IDX_ONE;
                state_q <= S_DN_LAST;
              end
            end
            OP_PUSH: begin
              if (count_q == '0) begin
                root_q <= bus.write_data;
              end else begin
                idx_q   <= cnt_ext + (W_A+1)'(1);
                new_q   <= bus.write_data;
                state_q <= S_UP_RD;
              end
            end
            default: ;
          endcase
        end
        S_UP_RD: state_q <= S_UP_CMP;
        S_UP_CMP: begin
          if (par_better) begin
            state_q <= S_IDLE;
          end else if (par_idx == IDX_ONE) begin
            root_q  <= new_q;
            state_q <= S_IDLE;
          end else begin
            idx_q   <= par_idx;
            state_q <= S_UP_RD;
          end
        end
        S_DN_LAST: begin
          new_q   <= ram_rdata;
          state_q <= S_DN_RDL;
        end
        S_DN_RDL: state_q <= (left_idx > cnt_ext) ? S_DN_END : S_DN_RDR;
        S_DN_RDR: begin
          left_q  <= ram_rdata;
          state_q <= S_DN_CMP;
        end
        S_DN_CMP: begin
          if (new_better) begin
            state_q <= S_DN_END;
          end else begin
            if (idx_q == IDX_ONE) root_q <= child_v;
            idx_q   <= child_idx;
            state_q <= S_DN_RDL;
          end
        end
        S_DN_END: begin
          if (idx_q == IDX_ONE) root_q <= new_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.write_ready = wr_rdy;
  assign bus.read_ready  = rd_rdy;
  assign bus.read_data   = rdata_q;
  assign bus.read_valid  = rvalid_q;
  assign bus.read_empty  = (count_q == '0);
  assign bus.full        = full;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_heap_pq.sv
// Directed bench for heap_pq: a min heap, a max heap and a small (W_A=3) min
// heap are driven through push, pop, replace, full, empty and reset cases.
module tb_heap_pq;
  import heap_pq_pkg::*;

  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  heap_pq_if #(.W_D(32), .W_A(8)) if0 ();
  heap_pq_if #(.W_D(32), .W_A(8)) if1 ();
  heap_pq_if #(.W_D(32), .W_A(3)) if2 ();

  heap_pq #(.W_D(32), .W_A(8), .MODE_MIN(1)) dutMin   (.CLK(clk), .RST(rst), .bus(if0.slave));
  heap_pq #(.W_D(32), .W_A(8), .MODE_MIN(0)) dutMax   (.CLK(clk), .RST(rst), .bus(if1.slave));
  heap_pq #(.W_D(32), .W_A(3), .MODE_MIN(1)) dutSmall (.CLK(clk), .RST(rst), .bus(if2.slave));

  logic        wv   [3];
  logic [31:0] wd   [3];
  logic        rr   [3];
  logic        wRdy [3];
  logic        rRdy [3];
  logic        rVal [3];
  logic        rEmp [3];
  logic        fullS[3];
  logic [31:0] rDat [3];
  logic [7:0]  cnt  [3];
  logic [7:0]  maxc [3];

  assign if0.write_valid = wv[0];
  assign if0.write_data  = wd[0];
  assign if0.read_request = rr[0];
  assign if1.write_valid = wv[1];
  assign if1.write_data  = wd[1];
  assign if1.read_request = rr[1];
  assign if2.write_valid = wv[2];
  assign if2.write_data  = wd[2];
  assign if2.read_request = rr[2];

  assign wRdy[0] = if0.write_ready;  assign rRdy[0] = if0.read_ready;
  assign rVal[0] = if0.read_valid;   assign rEmp[0] = if0.read_empty;
  assign fullS[0] = if0.full;        assign rDat[0] = if0.read_data;
  assign cnt[0]  = if0.count;        assign maxc[0] = if0.max_count;
  assign wRdy[1] = if1.write_ready;  assign rRdy[1] = if1.read_ready;
  assign rVal[1] = if1.read_valid;   assign rEmp[1] = if1.read_empty;
  assign fullS[1] = if1.full;        assign rDat[1] = if1.read_data;
  assign cnt[1]  = if1.count;        assign maxc[1] = if1.max_count;
  assign wRdy[2] = if2.write_ready;  assign rRdy[2] = if2.read_ready;
  assign rVal[2] = if2.read_valid;   assign rEmp[2] = if2.read_empty;
  assign fullS[2] = if2.full;        assign rDat[2] = if2.read_data;
  assign cnt[2]  = {5'b0, if2.count}; assign maxc[2] = {5'b0, if2.max_count};

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One push, pop or replace; pop-type ops check the returned key and its strobe.
  task automatic applyStimulus(input int s, input op_e op, input logic [31:0] val,
                               input logic [31:0] expData);
    int n = 0;
    @(negedge clk);
    while (!((op == OP_PUSH) ? wRdy[s] : rRdy[s]) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", 32'(n < LIMIT), 32'd1);
    wv[s] = (op != OP_POP);
    wd[s] = val;
    rr[s] = (op != OP_PUSH);
    @(posedge clk);
    #1;
    wv[s] = 1'b0;
    rr[s] = 1'b0;
    if (op != OP_PUSH) begin
      @(negedge clk);
      checkOutput("read_valid", 32'(rVal[s]), 32'd1);
      checkOutput("read_data", rDat[s], expData);
      @(negedge clk);
      checkOutput("read_valid_strobe_end", 32'(rVal[s]), 32'd0);
    end
  endtask

  task automatic waitIdle(input int s);
    int n = 0;
    @(negedge clk);
    while (!(rRdy[s] || wRdy[s]) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait", 32'(n < LIMIT), 32'd1);
  endtask

  initial begin
    logic [31:0] pushSeq [4];
    logic [31:0] minPops [4];
    logic [31:0] maxPops [4];
    logic [31:0] smallPush [7];
    logic [31:0] smallPops [7];
    pushSeq   = '{32'd5, 32'd3, 32'd8, 32'd1};
    minPops   = '{32'd1, 32'd3, 32'd5, 32'd8};
    maxPops   = '{32'd8, 32'd5, 32'd3, 32'd1};
    smallPush = '{32'd9, 32'd2, 32'd7, 32'd4, 32'd6, 32'd1, 32'd5};
    smallPops = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd9};
    for (int i = 0; i < 3; i++) begin
      wv[i] = 1'b0;
      wd[i] = '0;
      rr[i] = 1'b0;
    end

    $display("[TB] reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_count", 32'(cnt[0]), 32'd0);
    checkOutput("reset_empty", 32'(rEmp[0]), 32'd1);
    checkOutput("reset_read_valid", 32'(rVal[0]), 32'd0);
    checkOutput("reset_read_data", rDat[0], 32'd0);
    checkOutput("reset_write_ready", 32'(wRdy[0]), 32'd1);
    checkOutput("reset_read_ready", 32'(rRdy[0]), 32'd0);
    checkOutput("reset_max_count", 32'(maxc[0]), 32'd0);
    checkOutput("reset_full_small", 32'(fullS[2]), 32'd0);

    $display("[TB] min and max ordering");
    for (int i = 0; i < 4; i++) applyStimulus(0, OP_PUSH, pushSeq[i], 32'd0);
    checkOutput("min_count4", 32'(cnt[0]), 32'd4);
    for (int i = 0; i < 4; i++) applyStimulus(0, OP_POP, 32'd0, minPops[i]);
    waitIdle(0);
    checkOutput("min_empty", 32'(rEmp[0]), 32'd1);
    checkOutput("min_count0", 32'(cnt[0]), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1, OP_PUSH, pushSeq[i], 32'd0);
    checkOutput("max_count4", 32'(cnt[1]), 32'd4);
    for (int i = 0; i < 4; i++) applyStimulus(1, OP_POP, 32'd0, maxPops[i]);
    waitIdle(1);
    checkOutput("max_empty", 32'(rEmp[1]), 32'd1);

    $display("[TB] replace");
    applyStimulus(0, OP_PUSH, 32'd2, 32'd0);
    applyStimulus(0, OP_PUSH, 32'd4, 32'd0);
    applyStimulus(0, OP_PUSH, 32'd6, 32'd0);
    applyStimulus(0, OP_REPLACE, 32'd5, 32'd2);
    waitIdle(0);
    checkOutput("replace_count", 32'(cnt[0]), 32'd3);
    applyStimulus(0, OP_POP, 32'd0, 32'd4);
    applyStimulus(0, OP_POP, 32'd0, 32'd5);
    applyStimulus(0, OP_POP, 32'd0, 32'd6);

    $display("[TB] full small heap");
    for (int i = 0; i < 7; i++) applyStimulus(2, OP_PUSH, smallPush[i], 32'd0);
    waitIdle(2);
    checkOutput("small_full", 32'(fullS[2]), 32'd1);
    checkOutput("small_write_ready_full", 32'(wRdy[2]), 32'd0);
    checkOutput("small_count7", 32'(cnt[2]), 32'd7);
    applyStimulus(2, OP_REPLACE, 32'd3, 32'd1);
    waitIdle(2);
    checkOutput("small_count_after_replace", 32'(cnt[2]), 32'd7);
    checkOutput("small_full_after_replace", 32'(fullS[2]), 32'd1);
    for (int i = 0; i < 7; i++) applyStimulus(2, OP_POP, 32'd0, smallPops[i]);
    waitIdle(2);
    checkOutput("small_empty", 32'(rEmp[2]), 32'd1);
    checkOutput("small_not_full", 32'(fullS[2]), 32'd0);

    $display("[TB] equal keys and empty pop");
    for (int i = 0; i < 3; i++) applyStimulus(0, OP_PUSH, 32'd4, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, OP_POP, 32'd0, 32'd4);
    waitIdle(0);
    checkOutput("empty_read_ready", 32'(rRdy[0]), 32'd0);
    rr[0] = 1'b1;
    @(posedge clk);
    #1 rr[0] = 1'b0;
    @(negedge clk);
    checkOutput("empty_pop_no_valid", 32'(rVal[0]), 32'd0);
    checkOutput("empty_pop_count", 32'(cnt[0]), 32'd0);

    $display("[TB] reset during upheap");
    applyStimulus(0, OP_PUSH, 32'd10, 32'd0);
    applyStimulus(0, OP_PUSH, 32'd20, 32'd0);
    applyStimulus(0, OP_PUSH, 32'd30, 32'd0);
    applyStimulus(0, OP_PUSH, 32'd40, 32'd0);
    applyStimulus(0, OP_PUSH, 32'd50, 32'd0);
    applyStimulus(0, OP_PUSH, 32'd1, 32'd0);
    checkOutput("pre_reset_busy", 32'(wRdy[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_count", 32'(cnt[0]), 32'd0);
    checkOutput("abort_empty", 32'(rEmp[0]), 32'd1);
    checkOutput("abort_idle", 32'(wRdy[0]), 32'd1);
    checkOutput("abort_max_count", 32'(maxc[0]), 32'd0);
    for (int i = 6; i >= 1; i--) applyStimulus(0, OP_PUSH, 32'(i), 32'd0);
    checkOutput("post_reset_count6", 32'(cnt[0]), 32'd6);
`ifdef HEAP_PQ_STATS_EN
    checkOutput("post_reset_max_count", 32'(maxc[0]), 32'd6);
`else
    checkOutput("post_reset_max_count", 32'(maxc[0]), 32'd0);
`endif
    applyStimulus(0, OP_POP, 32'd0, 32'd1);
    applyStimulus(0, OP_POP, 32'd0, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
